// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, and feeds decode through the IF/ID register. A one-entry skid
// register catches a word that returns while decode is stalled. When no valid
// instruction is held, a NOP (16'h0800) is presented to decode.
module fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] PC_2,
  output logic        if_valid,
  output logic        halted,
  output logic        err
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state;
  logic [15:0] pc, addr_q;
  logic        outstanding, squash;
  logic        ifid_v, skid_v;
  logic [15:0] ifid_instr, ifid_pc2, skid_instr, skid_pc2;

  logic        take_halt, take_redir, can_issue, issue, odd_stop, done, accept;
  logic [15:0] req_addr, next_pc2;

  // Redirect and halt only count when decode actually consumes the IF/ID word;
  // halt wins when both are raised together.
  assign take_halt  = (state == RUN) & halt & ifid_v & ~stall;
  assign take_redir = (state == RUN) & redirect & ifid_v & ~stall & ~halt;

  // A new read may start only when nothing is in flight, the skid is empty and
  // the IF/ID word is leaving (or absent). An odd PC stops fetch instead.
  assign can_issue = (state == RUN) & ~outstanding & ~skid_v & ~(stall & ifid_v)
                     & ~take_halt & ~take_redir;
  assign issue     = can_issue & ~pc[0];
  assign odd_stop  = can_issue & pc[0];

  // Address is held from issue until completion so memory sees it stable.
  assign req_addr  = outstanding ? addr_q : pc;
  assign imem_req  = ~rst & (outstanding | issue);
  assign imem_addr = rst ? 16'h0000 : req_addr;
  assign done      = imem_req & imem_ready;
  assign next_pc2  = req_addr + 16'd2;

  // Returned word is kept only if it is still on the correct path.
  assign accept = done & ~squash & (state == RUN) & ~take_halt & ~take_redir;

  assign instruction = ifid_v ? ifid_instr : NOP;
  assign PC_2        = ifid_pc2;
  assign if_valid    = ifid_v;

  // Control FSM: run, drain a dropped access after halt, or stop for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take_halt) begin
            if (outstanding && !imem_ready) begin
              state <= DRAIN;
            end else begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end else if (odd_stop) begin
            state  <= HALTED;
            halted <= 1'b1;
            err    <= 1'b1;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

  // Memory handshake bookkeeping and PC advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= 16'h0000;
      addr_q      <= 16'h0000;
      outstanding <= 1'b0;
      squash      <= 1'b0;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
        addr_q      <= pc;
      end
      if (done) begin
        outstanding <= 1'b0;
        squash      <= 1'b0;
      end
      if (accept) pc <= next_pc2;
      if (take_redir) begin
        pc <= redirect_target;
        // A wrong-path read still in flight must be thrown away on return.
        if (outstanding && !imem_ready) squash <= 1'b1;
      end
    end
  end

  // IF/ID register and skid: hold under stall, drain skid first, else take new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_v     <= 1'b0;
      ifid_instr <= 16'h0000;
      ifid_pc2   <= 16'h0000;
      skid_v     <= 1'b0;
      skid_instr <= 16'h0000;
      skid_pc2   <= 16'h0000;
    end else if (take_halt || take_redir || odd_stop || state != RUN) begin
      ifid_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!stall || !ifid_v) begin
      if (skid_v) begin
        ifid_v     <= 1'b1;
        ifid_instr <= skid_instr;
        ifid_pc2   <= skid_pc2;
        skid_v     <= 1'b0;
      end else if (accept) begin
        ifid_v     <= 1'b1;
        ifid_instr <= imem_data;
        ifid_pc2   <= next_pc2;
      end else begin
        ifid_v <= 1'b0;
      end
    end else if (accept) begin
      skid_v     <= 1'b1;
      skid_instr <= imem_data;
      skid_pc2   <= next_pc2;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a queue-based behavioural model of the fetch stage is
// stepped alongside the DUT and compared every cycle; directed sequences pin
// the model with hand-computed values. Memory answers with random latency.
module tb_fetch;

  logic        clk, rst, stall, redirect, halt;
  logic [15:0] redirect_target;
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instruction, PC_2;
  logic        if_valid, halted, err;

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .instruction(instruction), .PC_2(PC_2),
    .if_valid(if_valid), .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] p2;
  } ent_t;

  // Model state: held instructions as a queue (front = what decode sees).
  ent_t        mq[$];
  logic [15:0] m_pc, m_addr;
  logic        m_busy, m_squash, m_err, m_init;
  int          m_mode;          // 0 running, 1 draining, 2 halted

  // Memory model state
  int mem_cnt, max_lat, fixed_lat;
  logic mem_busy;

  function automatic logic [15:0] word(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: memory responds, outputs are compared, model advances.
  task automatic step();
    logic ifv, th, tr, wi, e_req, done;
    logic [15:0] e_a;
    ent_t e;
    #1;
    if (imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, max_lat));
      end
      if (mem_cnt == 0) begin
        imem_ready = 1'b1;
        imem_data  = word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ready = 1'b0;
        imem_data  = 16'($urandom);
        mem_cnt--;
      end
    end else begin
      imem_ready = 1'b0;
      imem_data  = 16'($urandom);
      mem_busy   = 1'b0;
    end
    #1;
    ifv   = mq.size() > 0;
    th    = (m_mode == 0) && halt && ifv && !stall;
    tr    = (m_mode == 0) && redirect && ifv && !stall && !th;
    wi    = (m_mode == 0) && !m_busy && (mq.size() == 0 || (mq.size() == 1 && !stall)) && !th && !tr;
    e_a   = m_busy ? m_addr : m_pc;
    e_req = !rst && (m_busy || (wi && !m_pc[0]));
    if (m_init) begin
      chkb("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, e_a);
      chkb("if_valid", if_valid, ifv);
      chk("instruction", instruction, ifv ? mq[0].i : 16'h0800);
      if (ifv) chk("PC_2", PC_2, mq[0].p2);
      chkb("halted", halted, m_mode == 2);
      chkb("err", err, m_err);
    end
    done = e_req && imem_ready;
    if (rst) begin
      mq.delete();
      m_pc = 16'h0000; m_addr = 16'h0000;
      m_busy = 1'b0; m_squash = 1'b0; m_err = 1'b0; m_mode = 0; m_init = 1'b1;
    end else if (m_mode == 1) begin
      if (done) begin m_busy = 1'b0; m_mode = 2; end
    end else if (m_mode == 0) begin
      if (th) begin
        mq.delete();
        if (m_busy && !imem_ready) m_mode = 1;
        else begin m_busy = 1'b0; m_mode = 2; end
      end else if (tr) begin
        mq.delete();
        m_pc = redirect_target;
        if (m_busy && !imem_ready) m_squash = 1'b1;
        else begin m_busy = 1'b0; m_squash = 1'b0; end
      end else begin
        if (mq.size() > 0 && !stall) void'(mq.pop_front());
        if (wi && m_pc[0]) begin
          m_err = 1'b1; m_mode = 2; mq.delete();
        end else begin
          if (wi) begin m_busy = 1'b1; m_addr = m_pc; end
          if (done) begin
            m_busy = 1'b0;
            if (m_squash) m_squash = 1'b0;
            else begin
              e.i  = word(e_a);
              e.p2 = e_a + 16'd2;
              mq.push_back(e);
              m_pc = e_a + 16'd2;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    bit seen;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_target = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;
    m_init = 1'b0; mem_busy = 1'b0; mem_cnt = 0; max_lat = 0; fixed_lat = 0;
    m_pc = 16'h0000; m_addr = 16'h0000; m_busy = 1'b0; m_squash = 1'b0; m_err = 1'b0; m_mode = 0;
    @(posedge clk); #1;
    step(); step();
    chkb("rst_req", imem_req, 1'b0);
    chkb("rst_if_valid", if_valid, 1'b0);
    chk("rst_instr", instruction, 16'h0800);
    chk("rst_pc2", PC_2, 16'h0000);
    chkb("rst_halted", halted, 1'b0);
    chkb("rst_err", err, 1'b0);

    // Zero-wait streaming from address 0
    rst = 1'b0; #1;
    chkb("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 16'h0000);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("stream_instr", instruction, 16'h1000 + 16'(i));
      chk("stream_pc2", PC_2, 16'(2 * (i + 1)));
      chkb("stream_valid", if_valid, 1'b1);
      step();
    end

    // Redirect with zero-wait memory: one bubble
    redirect = 1'b1; redirect_target = 16'h0040;
    step();
    redirect = 1'b0;
    chkb("redir_bubble_v", if_valid, 1'b0);
    chk("redir_bubble_i", instruction, 16'h0800);
    step();
    chk("redir_target_i", instruction, 16'h1020);
    chk("redir_target_pc2", PC_2, 16'h0042);

    // PC wrap at the top of memory
    redirect = 1'b1; redirect_target = 16'hFFFE;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_i", instruction, 16'h8FFF);
    chk("wrap_pc2", PC_2, 16'h0000);
    step();
    chk("wrap_next_i", instruction, 16'h1000);
    chk("wrap_next_pc2", PC_2, 16'h0002);
    chkb("wrap_err", err, 1'b0);

    // Halt and redirect together: halt wins
    halt = 1'b1; redirect = 1'b1; redirect_target = 16'h0080;
    step();
    halt = 1'b0; redirect = 1'b0;
    chkb("halt_halted", halted, 1'b1);
    chkb("halt_valid", if_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chkb("halt_hold", halted, 1'b1);
    end

    // Odd redirect target
    do_reset();
    repeat (3) step();
    redirect = 1'b1; redirect_target = 16'h0041;
    step();
    redirect = 1'b0;
    step();
    chkb("odd_err", err, 1'b1);
    chkb("odd_halted", halted, 1'b1);
    repeat (5) step();
    chkb("odd_err_hold", err, 1'b1);

    // Redirect followed by a slow memory
    do_reset();
    repeat (3) step();
    fixed_lat = 3;
    redirect = 1'b1; redirect_target = 16'h0040;
    step();
    redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (if_valid === 1'b1) seen = 1'b1;
      else begin
        chk("slow_bubble", instruction, 16'h0800);
        step();
      end
    end
    chkb("slow_seen", seen, 1'b1);
    chk("slow_target_i", instruction, 16'h1020);
    fixed_lat = 0;

    // Stall freezes IF/ID; reset mid-stall restarts at 0
    do_reset();
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      held = instruction;
      step();
      chk("stall_freeze", instruction, held);
    end
    rst = 1'b1;
    step();
    chkb("midrst_valid", if_valid, 1'b0);
    chk("midrst_instr", instruction, 16'h0800);
    chkb("midrst_halted", halted, 1'b0);
    rst = 1'b0; stall = 1'b0; #1;
    chkb("midrst_req", imem_req, 1'b1);
    chk("midrst_addr", imem_addr, 16'h0000);
    step();
    chk("midrst_first", instruction, 16'h1000);

    // Randomized traffic against the model
    fixed_lat = -1; max_lat = 3;
    for (int c = 0; c < 4000; c++) begin
      rst = (m_mode == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_target = ($urandom_range(0, 99) == 0) ? 16'($urandom) | 16'h0001
                                                     : 16'($urandom) & 16'hFFFE;
      halt = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
